// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (CPU / DMA) arbiter in front of a single-port memory.
// Grants are decided in the same cycle as the request. Ownership, the DMA burst
// counter, read-valid flags and the stall counter are registered.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_mode  CPU request (held until c_gnt)
//   c_gnt, c_rvalid, c_rdata          CPU grant, read valid, read data
//   d_req/d_we/d_addr/d_wdata/d_mode  DMA request (held until d_gnt)
//   d_lock                            DMA asks for burst ownership
//   d_gnt, d_rvalid, d_rdata          DMA grant, read valid, read data
//   m_en/m_we/m_addr/m_wdata/m_mode   memory access strobe and payload
//   m_rdata                           memory read data, one cycle after a read strobe
//   owner                             00 IDLE, 01 OWN_C, 10 OWN_D, 11 OWN_D_LOCK
//   stall_cnt                         saturating count of cycles with a waiting request
module mem_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             c_req,
    input  logic             c_we,
    input  logic [WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    input  logic [2:0]       c_mode,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [WIDTH-1:0] c_rdata,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [2:0]       d_mode,
    input  logic             d_lock,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,

    output logic             m_en,
    output logic             m_we,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic [2:0]       m_mode,
    input  logic [WIDTH-1:0] m_rdata,

    output logic [1:0]       owner,
    output logic [15:0]      stall_cnt
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        OWN_C      = 2'b01,
        OWN_D      = 2'b10,
        OWN_D_LOCK = 2'b11
    } owner_t;

    owner_t             state;
    logic               last_d;     // 1: DMA was granted most recently
    logic [BURST_W-1:0] burst;
    logic               gnt_c;
    logic               gnt_d;
    logic               stall_now;

    // Grant decision: contention resolved by forced CPU slot, then lock, then round robin
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (c_req && d_req) begin
                if (burst == BURST_MAX) begin
                    gnt_c = 1'b1;
                end else if (state == OWN_D_LOCK && d_lock) begin
                    gnt_d = 1'b1;
                end else if (last_d) begin
                    gnt_c = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_c = c_req;
                gnt_d = d_req;
            end
        end
    end

    assign stall_now = (c_req & ~gnt_c) | (d_req & ~gnt_d);

    // Memory side mux; write enable is forced low when nobody is granted
    assign m_en    = gnt_c | gnt_d;
    assign m_we    = gnt_d ? d_we    : (gnt_c & c_we);
    assign m_addr  = gnt_d ? d_addr  : c_addr;
    assign m_wdata = gnt_d ? d_wdata : c_wdata;
    assign m_mode  = gnt_d ? d_mode  : c_mode;

    assign c_gnt   = gnt_c;
    assign d_gnt   = gnt_d;
    assign c_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign owner   = state;

    // Ownership, burst tracking, read-return tags and stall accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            burst     <= '0;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (gnt_c) begin
                state <= OWN_C;
            end else if (gnt_d) begin
                state <= d_lock ? OWN_D_LOCK : OWN_D;
            end else begin
                state <= IDLE;
            end

            if (gnt_c || gnt_d) begin
                last_d <= gnt_d;
            end

            // Held at MAX_BURST by uncontended locked grants so a later CPU request still gets its slot
            if (gnt_d && d_lock) begin
                burst <= (burst == BURST_MAX) ? burst : burst + BURST_W'(1);
            end else begin
                burst <= '0;
            end

            c_rvalid <= gnt_c & ~c_we;
            d_rvalid <= gnt_d & ~d_we;

            if (stall_now && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a stimulus process drives requests and pushes
// the reference model's expectations; a negedge monitor pops and compares.
module tb_mem_arbiter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MAX_BURST = 8;
    localparam int          O_IDLE    = 0;
    localparam int          O_C       = 1;
    localparam int          O_D       = 2;
    localparam int          O_DL      = 3;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mode;
        logic        lock;
    } req_t;

    typedef struct {
        logic        rst;
        logic        known;
        logic        gc;
        logic        gd;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mode;
        int          owner;
        int          stall;
        logic        crv;
        logic        drv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_mode, d_mode;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_mode;
    logic [1:0]  owner;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_mode(c_mode),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
        .m_rdata(m_rdata), .owner(owner), .stall_cnt(stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    exp_t        cyc_q[$];
    logic [31:0] crd_q[$];
    logic [31:0] drd_q[$];

    logic [31:0] hw_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Reference model state, in the terms the arbiter is described with
    bit md_known  = 0;
    int md_owner  = O_IDLE;
    bit md_last_d = 1;
    int md_burst  = 0;
    int md_stall  = 0;
    bit md_crv    = 0;
    bit md_drv    = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Memory: one-cycle read latency, writes land on the strobe edge
    always @(posedge clk) begin
        if (m_en && m_we) begin
            hw_mem[m_addr] = m_wdata;
        end else if (m_en) begin
            m_rdata <= hw_mem.exists(m_addr) ? hw_mem[m_addr] : mem_init(m_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t idle_req();
        req_t q;
        q.req = 0; q.we = 0; q.addr = '0; q.wdata = '0; q.mode = '0; q.lock = 0;
        return q;
    endfunction

    function automatic req_t rand_req(input int pct, input int lock_pct);
        req_t q;
        q.req   = int'($urandom_range(0, 99)) < pct;
        q.we    = 1'($urandom_range(0, 1));
        q.addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        q.wdata = $urandom;
        q.mode  = 3'($urandom_range(0, 7));
        q.lock  = int'($urandom_range(0, 99)) < lock_pct;
        return q;
    endfunction

    // One clock of stimulus: drive, predict, queue expectations, advance model
    task automatic do_cycle(input logic r, input req_t c, input req_t d,
                            output logic gc, output logic gd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        c_req = c.req; c_we = c.we; c_addr = c.addr; c_wdata = c.wdata; c_mode = c.mode;
        d_req = d.req; d_we = d.we; d_addr = d.addr; d_wdata = d.wdata; d_mode = d.mode;
        d_lock = d.lock;

        gc = 0; gd = 0;
        if (!r) begin
            if (c.req && !d.req)      gc = 1;
            else if (d.req && !c.req) gd = 1;
            else if (c.req && d.req) begin
                if (md_burst == MAX_BURST)          gc = 1;
                else if (md_owner == O_DL && d.lock) gd = 1;
                else if (md_last_d)                 gc = 1;
                else                                gd = 1;
            end
        end

        e.rst   = r;
        e.known = md_known;
        e.gc    = gc;
        e.gd    = gd;
        e.we    = gc ? c.we : (gd ? d.we : 1'b0);
        e.addr  = gc ? c.addr : d.addr;
        e.wdata = gc ? c.wdata : d.wdata;
        e.mode  = gc ? c.mode : d.mode;
        e.owner = md_owner;
        e.stall = md_stall;
        e.crv   = md_crv;
        e.drv   = md_drv;
        cyc_q.push_back(e);

        if (gc) begin
            if (c.we) ref_mem[c.addr] = c.wdata;
            else      crd_q.push_back(ref_rd(c.addr));
        end
        if (gd) begin
            if (d.we) ref_mem[d.addr] = d.wdata;
            else      drd_q.push_back(ref_rd(d.addr));
        end

        if (r) begin
            md_known = 1; md_owner = O_IDLE; md_last_d = 1; md_burst = 0;
            md_stall = 0; md_crv = 0; md_drv = 0;
        end else begin
            md_owner  = gc ? O_C : (gd ? (d.lock ? O_DL : O_D) : O_IDLE);
            if (gc || gd) md_last_d = gd;
            md_burst  = (gd && d.lock) ? ((md_burst < MAX_BURST) ? md_burst + 1 : md_burst) : 0;
            if (((c.req && !gc) || (d.req && !gd)) && md_stall < 65535) md_stall++;
            md_crv = gc && !c.we;
            md_drv = gd && !d.we;
        end
    endtask

    // Monitor: compare the cycle's predicted behaviour, pop read data on rvalid
    always @(negedge clk) begin
        exp_t e;
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            chk("c_gnt", 32'(c_gnt), 32'(e.gc));
            chk("d_gnt", 32'(d_gnt), 32'(e.gd));
            chk("m_en", 32'(m_en), 32'(e.gc | e.gd));
            chk("m_we", 32'(m_we), 32'(e.we));
            if (e.gc || e.gd) begin
                chk("m_addr", m_addr, e.addr);
                chk("m_wdata", m_wdata, e.wdata);
                chk("m_mode", 32'(m_mode), 32'(e.mode));
            end
            if (e.known) begin
                chk("owner", 32'(owner), 32'(e.owner));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            end
            if (e.rst) begin
                crd_q.delete();
                drd_q.delete();
            end else begin
                chk("c_rvalid", 32'(c_rvalid), 32'(e.crv));
                chk("d_rvalid", 32'(d_rvalid), 32'(e.drv));
                if (c_rvalid === 1'b1) begin
                    if (crd_q.size() == 0) chk("c_rdata_queue", 32'd0, 32'd1);
                    else                   chk("c_rdata", c_rdata, crd_q.pop_front());
                end
                if (d_rvalid === 1'b1) begin
                    if (drd_q.size() == 0) chk("d_rdata_queue", 32'd0, 32'd1);
                    else                   chk("d_rdata", d_rdata, drd_q.pop_front());
                end
            end
        end
    end

    task automatic reset_cycles(input int n);
        logic gc, gd;
        for (int i = 0; i < n; i++) do_cycle(1'b1, idle_req(), idle_req(), gc, gd);
    endtask

    task automatic idle_cycles(input int n);
        logic gc, gd;
        for (int i = 0; i < n; i++) do_cycle(1'b0, idle_req(), idle_req(), gc, gd);
    endtask

    // Random traffic; an ungranted request is held unchanged until granted
    task automatic run_random(input int n, input int c_pct, input int d_pct,
                              input int lock_pct, input int rst_pct);
        req_t c, d;
        logic gc, gd, r;
        bit   cp, dp;
        cp = 0; dp = 0;
        c = idle_req(); d = idle_req();
        for (int i = 0; i < n; i++) begin
            if (!cp) c = rand_req(c_pct, 0);
            if (!dp) d = rand_req(d_pct, lock_pct);
            r = int'($urandom_range(0, 99)) < rst_pct;
            do_cycle(r, c, d, gc, gd);
            cp = c.req && !gc;
            dp = d.req && !gd;
        end
    endtask

    initial begin
        req_t c, d;
        logic gc, gd;
        rst = 1; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_mode = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mode = '0; d_lock = 0;

        reset_cycles(3);

        // CPU read of 0x100 alone right after reset
        c = idle_req(); c.req = 1; c.addr = 32'h100; c.mode = 3'd2;
        do_cycle(1'b0, c, idle_req(), gc, gd);
        idle_cycles(1);

        // Unlocked contention for four cycles: C,D,C,D and four stalls
        reset_cycles(1);
        c = idle_req(); c.req = 1; c.addr = 32'h10; c.we = 1; c.wdata = 32'hCAFE_0001;
        d = idle_req(); d.req = 1; d.addr = 32'h14; d.we = 1; d.wdata = 32'hD00D_0002;
        for (int i = 0; i < 4; i++) do_cycle(1'b0, c, d, gc, gd);
        idle_cycles(1);
        @(negedge clk);
        chk("stall_after_contention", 32'(stall_cnt), 32'd4);

        // Locked DMA burst against a continuous CPU request
        reset_cycles(1);
        c = idle_req(); c.req = 1; c.addr = 32'h20;
        d = idle_req(); d.req = 1; d.addr = 32'h24; d.lock = 1;
        for (int i = 0; i < 2 + MAX_BURST; i++) do_cycle(1'b0, c, d, gc, gd);
        idle_cycles(1);
        @(negedge clk);
        chk("owner_after_forced_cpu", 32'(owner), 32'(O_C));

        // CPU read then DMA read on consecutive cycles
        c = idle_req(); c.req = 1; c.addr = 32'h10;
        d = idle_req(); d.req = 1; d.addr = 32'h14;
        do_cycle(1'b0, c, idle_req(), gc, gd);
        do_cycle(1'b0, idle_req(), d, gc, gd);
        idle_cycles(2);

        // Reset right after a granted read discards the return
        c = idle_req(); c.req = 1; c.addr = 32'h30;
        do_cycle(1'b0, c, idle_req(), gc, gd);
        reset_cycles(1);
        idle_cycles(2);

        // Mixed random traffic, including lock bursts and occasional resets
        run_random(3000, 60, 60, 50, 1);
        run_random(600, 90, 90, 90, 0);
        run_random(400, 30, 30, 0, 0);

        // Permanent contention drives the stall counter into saturation
        reset_cycles(1);
        run_random(70000, 100, 100, 0, 0);
        idle_cycles(1);
        @(negedge clk);
        chk("stall_saturated", 32'(stall_cnt), 32'h0000_FFFF);

        idle_cycles(2);
        for (int i = 0; i < 20 && cyc_q.size() != 0; i++) @(negedge clk);
        chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
        chk("c_read_queue_drained", 32'(crd_q.size()), 32'd0);
        chk("d_read_queue_drained", 32'(drd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
